// File: rtl/histogram_equalizer_pkg.sv
// Shared widths and FSM encoding for the histogram equalizer.
// The LUT builder walks all histogram bins once per build request.
package histo_pkg;
    localparam int GRAY_W   = 8;
    localparam int HIST_W   = 20;
    localparam int NUM_BINS = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } histo_state_e;
endpackage

// File: rtl/histogram_equalizer_if.sv
// Bus bundles: the LUT RAM write/read port and a plain pixel stream.
// Pixel stream: gray is meaningful only in a cycle where valid=1; there is no backpressure.
interface histo_lut_if;
    import histo_pkg::*;
    logic              wr_en;
    logic [GRAY_W-1:0] wr_addr;
    logic [GRAY_W-1:0] wr_data;
    logic [GRAY_W-1:0] rd_addr;
    logic [GRAY_W-1:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

interface histo_pix_if;
    import histo_pkg::*;
    logic              valid;
    logic [GRAY_W-1:0] gray;

    modport master (output valid, gray);
    modport slave  (input valid, gray);
endinterface

// File: rtl/histogram_equalizer_lut.sv
// 256x8 equalization LUT: one synchronous write port, one registered read port.
// Contents are intentionally not reset; a read of an address written in the same cycle returns the old entry.
module eq_lut
    import histo_pkg::*;
(
    input logic        clk_i,
    histo_lut_if.slave lut
);

    logic [GRAY_W-1:0] mem_q [NUM_BINS];

    always_ff @(posedge clk_i) begin
        if (lut.wr_en) begin
            mem_q[lut.wr_addr] <= lut.wr_data;
        end
        lut.rd_data <= mem_q[lut.rd_addr];
    end

endmodule

// File: rtl/histogram_equalizer.sv
// Builds a gray-level equalization LUT from a 256-bin histogram and remaps a pixel stream through it.
// Histogram reads have one cycle of latency, so each bin is accumulated one cycle after its address.
module histogram_equalizer
    import histo_pkg::*;
#(
    parameter int TOTAL_PIXELS = 384000,
    parameter int SCALE_K      = 349,
    parameter int SCALE_SHIFT  = 19
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    output logic [GRAY_W-1:0] oHistAddr,
    input  logic [HIST_W-1:0] iHistVal,
    output logic              oBusy,
    output logic              oDone,
    input  logic              iValid,
    input  logic [GRAY_W-1:0] iGray,
    output logic              oValid,
    output logic [GRAY_W-1:0] oGray,
    output histo_state_e      oDbgState
);

    histo_state_e      state_q;
    logic [GRAY_W-1:0] addr_q;
    logic [HIST_W-1:0] cdf_q;
    logic [HIST_W-1:0] cdf_d;
    logic              busy_q;
    logic              done_q;
    logic              lut_ready_q;
    logic              valid_q;
    logic [GRAY_W-1:0] gray_q;

    logic [HIST_W:0]   sum_w;
    logic [31:0]       prod_w;
    logic [31:0]       scaled_w;
    logic [GRAY_W-1:0] lut_val_w;

    histo_lut_if lut_bus ();

    // Saturating accumulate: a corrupt or oversized bin must never wrap the CDF.
    always_comb begin
        sum_w    = {1'b0, cdf_q} + {1'b0, iHistVal};
        cdf_d    = sum_w[HIST_W] ? '1 : sum_w[HIST_W-1:0];
        prod_w   = 32'(cdf_d) * 32'(SCALE_K);
        scaled_w = prod_w >> SCALE_SHIFT;
        // A full frame maps to white even when SCALE_K rounds down.
        if (scaled_w > 32'd255 || 32'(cdf_d) >= 32'(TOTAL_PIXELS)) begin
            lut_val_w = '1;
        end else begin
            lut_val_w = scaled_w[GRAY_W-1:0];
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cdf_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lut_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        state_q <= SCAN;
                        addr_q  <= '0;
                        cdf_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    addr_q <= addr_q + 8'd1;
                    if (addr_q != '0) begin
                        cdf_q <= cdf_d;
                    end
                    if (addr_q == GRAY_W'(NUM_BINS - 1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    cdf_q   <= cdf_d;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    lut_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bin being written trails the address by one; in DRAIN the address has wrapped to 0, so this yields 255.
    assign lut_bus.wr_en   = (state_q == SCAN && addr_q != '0) || (state_q == DRAIN);
    assign lut_bus.wr_addr = addr_q - 8'd1;
    assign lut_bus.wr_data = lut_val_w;
    assign lut_bus.rd_addr = iGray;

    eq_lut u_lut (
        .clk_i (iClk),
        .lut   (lut_bus)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            valid_q <= 1'b0;
            gray_q  <= '0;
        end else begin
            valid_q <= iValid;
            gray_q  <= iGray;
        end
    end

    assign oHistAddr = addr_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oValid    = valid_q;
    assign oGray     = lut_ready_q ? lut_bus.rd_data : gray_q;
    assign oDbgState = state_q;

endmodule
